// File: rtl/mult_sched_pkg.sv
// Shared types and defaults for the multiplier scheduler and its datapath.
// State encoding, requester ids and default widths live here.
// Optional feature macro used by the slice: MULT_EARLY_EXIT_EN.
package mult_sched_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    REQ_GP = 1'b0,
    REQ_FP = 1'b1
  } req_t;

endpackage

// File: rtl/mult_iter_dp.sv
// Shift-add multiply datapath: magnitudes, accumulator, step counter, final sign fix.
// Latency: one step per cycle; product register loads on the finish strobe.
// Backpressure: none, fully driven by load/step/finish strobes from mult_sched.
// MULT_EARLY_EXIT_EN adds a remaining-multiplier-is-zero detect to the last flag.
module mult_iter_dp
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               last,
  output logic [WIDTH-1:0]   product_hi,
  output logic [WIDTH-1:0]   product_lo
);

  logic [2*WIDTH-1:0] ma;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] result;
  logic               rest_zero;

  // Operand magnitudes at latch time; unsigned operands pass through untouched.
  always_comb begin
    a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag = (sgn && b[WIDTH-1]) ? -b : b;
  end

  // Accumulate the current multiplier bit; the final step's sum feeds the product directly.
  always_comb begin
    acc_next = acc + (mb[0] ? ma : '0);
    result   = neg ? -acc_next : acc_next;
  end

`ifdef MULT_EARLY_EXIT_EN
  // After this step nothing but zeros would remain to be shifted in.
  assign rest_zero = (mb[WIDTH-1:1] == '0);
`else
  assign rest_zero = 1'b0;
`endif

  assign last       = (cnt == CNT_W'(WIDTH-1)) || rest_zero;
  assign product_hi = prod[2*WIDTH-1:WIDTH];
  assign product_lo = prod[WIDTH-1:0];

  // Load operands, run one shift-add step per cycle, capture the signed result on finish.
  always_ff @(posedge clock) begin
    if (reset) begin
      ma   <= '0;
      mb   <= '0;
      acc  <= '0;
      neg  <= 1'b0;
      cnt  <= '0;
      prod <= '0;
    end else begin
      if (load) begin
        ma  <= {{WIDTH{1'b0}}, a_mag};
        mb  <= b_mag;
        acc <= '0;
        neg <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        cnt <= '0;
      end else if (step) begin
        acc <= acc_next;
        ma  <= ma << 1;
        mb  <= mb >> 1;
        cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        prod <= result;
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Round-robin arbiter and sequencer for the shared gp/fp multi-cycle multiplier.
// Latency: request in cycle 0, done pulse in cycle WIDTH+1 (earlier with MULT_EARLY_EXIT_EN).
// Backpressure: multStall held combinationally while any request is pending and not done.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             gpReq,
  input  logic [WIDTH-1:0] gpA,
  input  logic [WIDTH-1:0] gpB,
  input  logic             gpSigned,
  input  logic             fpReq,
  input  logic [WIDTH-1:0] fpA,
  input  logic [WIDTH-1:0] fpB,
  input  logic             fpSigned,
  output logic             multStall,
  output logic             gpDone,
  output logic             fpDone,
  output logic [WIDTH-1:0] productHi,
  output logic [WIDTH-1:0] productLo,
  output logic             busy
);

  state_t state;
  state_t state_next;
  req_t   grant;
  req_t   last_grant;
  req_t   pick;

  logic             load;
  logic             step;
  logic             finish;
  logic             last;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_sgn;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (gpReq || fpReq) state_next = BUSY;
      BUSY:    if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Arbitration: on a tie the requester not served last wins.
  always_comb begin
    pick = REQ_FP;
    if (gpReq && fpReq) pick = (last_grant == REQ_FP) ? REQ_GP : REQ_FP;
    else if (gpReq)     pick = REQ_GP;
    sel_a   = (pick == REQ_GP) ? gpA : fpA;
    sel_b   = (pick == REQ_GP) ? gpB : fpB;
    sel_sgn = (pick == REQ_GP) ? gpSigned : fpSigned;
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    load   = (state == IDLE) && (gpReq || fpReq);
    step   = (state == BUSY);
    finish = (state == BUSY) && last;
  end

  // Grant bookkeeping and done pulses, which line up with the DONE state.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant      <= REQ_GP;
      last_grant <= REQ_FP;
      gpDone     <= 1'b0;
      fpDone     <= 1'b0;
    end else begin
      if (load) begin
        grant      <= pick;
        last_grant <= pick;
      end
      gpDone <= finish && (grant == REQ_GP);
      fpDone <= finish && (grant == REQ_FP);
    end
  end

  assign multStall = (gpReq && !gpDone) || (fpReq && !fpDone);
  assign busy      = (state != IDLE);

  mult_iter_dp #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .finish     (finish),
    .a          (sel_a),
    .b          (sel_b),
    .sgn        (sel_sgn),
    .last       (last),
    .product_hi (productHi),
    .product_lo (productLo)
  );

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: directed, tie, mid-op reset and randomized operations.
// Expected products come from plain 64-bit arithmetic, latencies from the bit-count rule.
// Honours MULT_EARLY_EXIT_EN when the same macro is defined for the build.
module tb_mult_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        gpReq, gpSigned, fpReq, fpSigned;
  logic [31:0] gpA, gpB, fpA, fpB;
  logic        multStall, gpDone, fpDone, busy;
  logic [31:0] productHi, productLo;

  int checks   = 0;
  int failures = 0;
  bit last_fp  = 1'b1;   // model of who was served last; reset says fp

  always #5 clock = ~clock;

  mult_sched dut (
    .clock     (clock),
    .reset     (reset),
    .gpReq     (gpReq),
    .gpA       (gpA),
    .gpB       (gpB),
    .gpSigned  (gpSigned),
    .fpReq     (fpReq),
    .fpA       (fpA),
    .fpB       (fpB),
    .fpSigned  (fpSigned),
    .multStall (multStall),
    .gpDone    (gpDone),
    .fpDone    (fpDone),
    .productHi (productHi),
    .productLo (productLo),
    .busy      (busy)
  );

  function automatic logic [63:0] exp_prod(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int exp_lat(input logic [31:0] b, input bit sgn);
`ifdef MULT_EARLY_EXIT_EN
    logic [31:0] mag;
    int msb;
    mag = (sgn && b[31]) ? -b : b;
    msb = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
    return 2 + msb;
`else
    return 33;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if ({gpDone, fpDone} !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", {gpDone, fpDone}); end
    checks++; if ({productHi, productLo} !== 64'd0) begin failures++; $display("FAIL reset_product got=%h exp=0", {productHi, productLo}); end
    checks++; if (multStall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", multStall); end
    next_cycle();
  endtask

  // One request from one side, scrambled operands after grant, timing checked every cycle.
  task automatic test_single_op(input bit use_gp, input logic [31:0] a, input logic [31:0] b,
                                input bit sgn, input string name);
    int          lat;
    logic [63:0] p;
    logic        my_done, other_done;
    lat = exp_lat(b, sgn);
    p   = exp_prod(a, b, sgn);
    if (use_gp) begin gpReq = 1; gpA = a; gpB = b; gpSigned = sgn; end
    else        begin fpReq = 1; fpA = a; fpB = b; fpSigned = sgn; end
    for (int k = 0; k <= lat; k++) begin
      if (k == 1) begin
        if (use_gp) begin gpA = $urandom; gpB = $urandom; gpSigned = ~sgn; end
        else        begin fpA = $urandom; fpB = $urandom; fpSigned = ~sgn; end
      end
      #1;
      my_done    = use_gp ? gpDone : fpDone;
      other_done = use_gp ? fpDone : gpDone;
      checks++;
      if (my_done !== (k == lat) || other_done !== 1'b0) begin
        failures++;
        $display("FAIL %s_done cyc=%0d got=%b/%b exp=%b/0", name, k, my_done, other_done, (k == lat));
      end
      checks++;
      if (multStall !== (k < lat)) begin
        failures++; $display("FAIL %s_stall cyc=%0d got=%0b exp=%0b", name, k, multStall, (k < lat));
      end
      checks++;
      if (busy !== (k >= 1)) begin
        failures++; $display("FAIL %s_busy cyc=%0d got=%0b exp=%0b", name, k, busy, (k >= 1));
      end
      if (k == lat) begin
        checks++;
        if ({productHi, productLo} !== p) begin
          failures++; $display("FAIL %s_product got=%h exp=%h", name, {productHi, productLo}, p);
        end
      end
      next_cycle();
    end
    gpReq = 0; fpReq = 0;
    #1;
    checks++;
    if ({productHi, productLo} !== p || busy !== 1'b0 || gpDone !== 1'b0 || fpDone !== 1'b0) begin
      failures++;
      $display("FAIL %s_hold got=%h busy=%0b done=%b%b exp=%h busy=0 done=00",
               name, {productHi, productLo}, busy, gpDone, fpDone, p);
    end
    last_fp = !use_gp;
    next_cycle();
  endtask

  task automatic test_directed();
    test_single_op(1'b1, 32'd5000, 32'd2, 1'b0, "gp_5000x2");
    test_single_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, "fp_neg1x2");
    test_single_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "gp_maxsq");
    test_single_op(1'b0, 32'd1234, 32'd0, 1'b0, "fp_zero_b");
    test_single_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, "gp_minsq");
  endtask

  // Both requests raised together; loser stays stalled and follows after one idle cycle.
  task automatic test_both(input logic [31:0] ga, input logic [31:0] gb,
                           input logic [31:0] fa, input logic [31:0] fb, input string name);
    bit          win_gp;
    int          dw, dl;
    logic [63:0] pw, pl;
    logic        wdone, ldone;
    win_gp = last_fp;
    dw = win_gp ? exp_lat(gb, 1'b0) : exp_lat(fb, 1'b0);
    dl = dw + 1 + (win_gp ? exp_lat(fb, 1'b0) : exp_lat(gb, 1'b0));
    pw = win_gp ? exp_prod(ga, gb, 1'b0) : exp_prod(fa, fb, 1'b0);
    pl = win_gp ? exp_prod(fa, fb, 1'b0) : exp_prod(ga, gb, 1'b0);
    gpA = ga; gpB = gb; gpSigned = 0;
    fpA = fa; fpB = fb; fpSigned = 0;
    for (int k = 0; k <= dl; k++) begin
      if (win_gp) begin gpReq = (k <= dw); fpReq = 1'b1; end
      else        begin fpReq = (k <= dw); gpReq = 1'b1; end
      #1;
      wdone = win_gp ? gpDone : fpDone;
      ldone = win_gp ? fpDone : gpDone;
      checks++;
      if (wdone !== (k == dw) || ldone !== (k == dl)) begin
        failures++;
        $display("FAIL %s_done cyc=%0d got win=%0b lose=%0b exp win=%0b lose=%0b",
                 name, k, wdone, ldone, (k == dw), (k == dl));
      end
      checks++;
      if (multStall !== (k < dl)) begin
        failures++; $display("FAIL %s_stall cyc=%0d got=%0b exp=%0b", name, k, multStall, (k < dl));
      end
      if (k == dw || k == dl) begin
        checks++;
        if ({productHi, productLo} !== ((k == dw) ? pw : pl)) begin
          failures++;
          $display("FAIL %s_product cyc=%0d got=%h exp=%h", name, k, {productHi, productLo}, (k == dw) ? pw : pl);
        end
      end
      next_cycle();
    end
    gpReq = 0; fpReq = 0;
    last_fp = win_gp;
    next_cycle();
  endtask

  // Reset mid-operation aborts with no done pulse; a reissue then runs normally.
  task automatic test_reset_mid();
    int lat;
    gpReq = 1; gpA = 32'd5000; gpB = 32'h8000_0000; gpSigned = 0;
    for (int k = 0; k <= 10; k++) begin
      if (k == 10) reset = 1;
      #1;
      checks++;
      if (gpDone !== 1'b0 || fpDone !== 1'b0) begin
        failures++; $display("FAIL rstmid_nodone cyc=%0d got=%b%b exp=00", k, gpDone, fpDone);
      end
      next_cycle();
    end
    reset = 0; gpReq = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || gpDone !== 1'b0 || {productHi, productLo} !== 64'd0 || multStall !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_clear got busy=%0b done=%0b prod=%h stall=%0b exp all 0",
               busy, gpDone, {productHi, productLo}, multStall);
    end
    last_fp = 1'b1;
    next_cycle();
    lat = exp_lat(32'd2, 1'b0);
    gpReq = 1; gpB = 32'd2;
    for (int k = 0; k <= lat; k++) begin
      #1;
      checks++;
      if (gpDone !== (k == lat)) begin
        failures++; $display("FAIL rstmid_reissue cyc=%0d got=%0b exp=%0b", k + 12, gpDone, (k == lat));
      end
      if (k == lat) begin
        checks++;
        if ({productHi, productLo} !== 64'd10000) begin
          failures++; $display("FAIL rstmid_product got=%h exp=%h", {productHi, productLo}, 64'd10000);
        end
      end
      next_cycle();
    end
    gpReq = 0;
    last_fp = 1'b0;
    next_cycle();
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int n = 0; n < 16; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = b >> $urandom_range(1, 31);
        1: b = 32'd0;
        default: ;
      endcase
      test_single_op($urandom_range(0, 1) == 1, a, b, $urandom_range(0, 1) == 1, "rand");
    end
  endtask

  initial begin
    reset = 1;
    gpReq = 0; gpA = 0; gpB = 0; gpSigned = 0;
    fpReq = 0; fpA = 0; fpB = 0; fpSigned = 0;
    repeat (3) @(posedge clock);
    #2;
    reset = 0;
    test_reset();
    reset = 1;
    next_cycle();
    reset = 0;
    last_fp = 1'b1;
    test_both(32'd7, 32'd3, 32'd4, 32'd5, "tie_gp_first");
    test_directed();
    test_both(32'd11, 32'd13, 32'd17, 32'hF000_0001, "tie_alt");
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
